rr_grant_encoder: RTL and testbench

Round-robin arbiter/encoder for 8 requesters. It sits directly upstream of the 3-to-8 decoder stage: it selects one active request and registers the 3-bit binary grant index. The decoder turns that index into the one-hot grant vector. The grant is held until the owner releases it with `done` or a hold timeout expires. Priority then rotates so that no requester starves.

---
 rtl/rr_grant_encoder_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_grant_encoder.sv | 110 +++++++++++
 tb/tb_rr_grant_encoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants and state encoding for the round-robin grant encoder.
//   N_REQ : number of requesters (fixed at 8 to match the 3-bit index)
//   IDX_W : width of the binary grant index
//   state_e : arbiter FSM state (idle / grant held)
package rr_grant_encoder_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search.
//   req : request vector, bit k = requester k
//   ptr : highest-priority index; search order ptr, ptr+1, ... wrapping mod N_REQ
//   any : at least one request set
//   idx : first set request found in search order (ptr when none set)
module rr_pick
  import rr_grant_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] k;

  // Walk from the lowest priority offset down so the nearest hit to ptr wins last.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    k   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 8 requesters producing a registered 3-bit grant index.
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   req         : level-sensitive request lines
//   done        : single-cycle release pulse from the current owner
//   grant_idx   : registered index of the current owner
//   grant_valid : registered, high while grant_idx is owned
//   timeout     : registered single-cycle pulse after a forced release
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              grant_valid_q, grant_valid_d;
  logic              timeout_q, timeout_d;

  logic [IDX_W-1:0]  pick_ptr;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              hold_expired;
  logic              release_ev;

  assign hold_expired = (state_q == StGrant) && (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);
  assign release_ev   = (state_q == StGrant) && (done || hold_expired);

  // While granted, search from the slot after the owner so a release re-arbitrates
  // with the rotated pointer in the same cycle.
  assign pick_ptr = (state_q == StGrant) ? grant_idx_q + IDX_W'(1) : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    // done wins over a coincident hold expiry, so no pulse in that case.
    timeout_d     = hold_expired && !done;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d       = StGrant;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      StGrant: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (release_ev) begin
          ptr_d      = pick_ptr;
          hold_cnt_d = '0;
          if (pick_any) begin
            grant_idx_d = pick_idx;
          end else begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
module tb_rr_grant_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks;
  int errors;

  rr_grant_encoder #(
    .MAX_HOLD (16),
    .HOLD_W   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] idx, input logic vld,
                         input logic to);
    chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(vld));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 8'hFF;
    done   = 1'b0;

    // Reset held two cycles with all requests up.
    tick();
    tick();
    chk_out("reset", 3'd0, 1'b0, 1'b0);

    rst = 1'b0;
    tick();
    chk_out("first_grant", 3'd0, 1'b1, 1'b0);

    // Strict rotation with done every third cycle.
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rot.hold_valid", 32'(grant_valid), 32'd1);
      tick();
      chk("rot.hold_idx", 32'(grant_idx), 32'(k - 1));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_out("rot", 3'(k), 1'b1, 1'b0);
    end

    // Steer the pointer to 6: grant 5 then release it.
    req  = 8'h20;
    done = 1'b1;
    tick();
    chk_out("steer5", 3'd5, 1'b1, 1'b0);
    req = 8'b0000_0101;
    tick();
    done = 1'b0;
    chk_out("wrap_to0", 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("skip_to2", 3'd2, 1'b1, 1'b0);
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("release_idle", 3'd2, 1'b0, 1'b0);

    // done in idle has no effect.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("done_in_idle", 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("idle_hold", 3'd2, 1'b0, 1'b0);

    // Timeout on a sole requester: 16 cycles held, then pulse and re-grant.
    req = 8'h10;
    tick();
    chk_out("to_grant", 3'd4, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_out("to_hold", 3'd4, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_pulse", 3'd4, 1'b1, 1'b1);
    tick();
    chk_out("to_after", 3'd4, 1'b1, 1'b0);

    // Owner drops its request; grant persists until done.
    req = 8'h00;
    tick();
    tick();
    tick();
    chk_out("drop_req", 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("drop_release", 3'd4, 1'b0, 1'b0);

    // done coincident with the hold limit is a normal release.
    req = 8'h08;
    tick();
    chk_out("sim_grant", 3'd3, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) tick();
    chk_out("sim_prelimit", 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("sim_done", 3'd3, 1'b1, 1'b0);
    tick();
    chk_out("sim_after", 3'd3, 1'b1, 1'b0);

    // Reset in the middle of a grant to 5 clears the pointer.
    req  = 8'h20;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("mid_grant5", 3'd5, 1'b1, 1'b0);
    req = 8'h21;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("mid_reset", 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("post_reset", 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
